// File: rtl/uart_mdio_cmd_rx.sv
// uart_mdio_cmd_rx
//   Receives 8N1 UART bytes on rxd and packs four consecutive bytes into one
//   32-bit MDIO command word for mdio_master. Byte 0 lands in word[7:0] and
//   byte 3 in word[31:24]. The completed command is held with a valid/ready
//   handshake. Framing errors and inter-byte timeouts are reported as
//   single-cycle pulses.
//
// Ports
//   clk125        in   system clock, all logic on posedge
//   reset         in   synchronous active-high reset
//   rxd           in   asynchronous UART line, idle high
//   cmd_phy_addr  out  word[4:0]
//   cmd_reg_addr  out  word[9:5]
//   cmd_opcode    out  word[15:14]
//   cmd_data      out  word[31:16]
//   cmd_valid     out  command word complete and stable
//   cmd_ready     in   consumer accepts when high together with cmd_valid
//   frame_err     out  1-cycle pulse, stop bit sampled low
//   timeout_err   out  1-cycle pulse, partial command dropped on timeout
//   busy          out  high in every state except IDLE
//
// state | meaning
// IDLE  | line idle, no partial command in progress
// START | half-bit wait, then confirm the start bit is still low
// DATA  | sampling 8 data bits LSB-first at mid-bit
// STOP  | sampling the stop bit
// GAP   | between bytes of a command, inter-byte timer running
// BREAK | framing error seen, waiting for the line to return high
// HOLD  | command complete, cmd_valid high until accepted

module uart_mdio_cmd_rx #(
   parameter int          BaudRateDivider = 1085,
   parameter logic [23:0] ByteTimeout     = 24'hFFFFFF
) (
   input  logic        clk125,
   input  logic        reset,
   input  logic        rxd,
   output logic [4:0]  cmd_phy_addr,
   output logic [4:0]  cmd_reg_addr,
   output logic [1:0]  cmd_opcode,
   output logic [15:0] cmd_data,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic        frame_err,
   output logic        timeout_err,
   output logic        busy
);

   localparam logic [23:0] HalfBit = 24'(BaudRateDivider / 2 - 1);
   localparam logic [23:0] FullBit = 24'(BaudRateDivider - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP, GAP, BREAK, HOLD
   } state_t;

   state_t      state, state_d;
   logic [1:0]  sync_q;
   logic        rxd_s;
   logic [23:0] cnt, cnt_d;
   logic [23:0] timer, timer_d;
   logic [31:0] word, word_d;
   logic [2:0]  bit_cnt, bit_cnt_d;
   logic [1:0]  byte_cnt, byte_cnt_d;
   logic        frame_err_d, timeout_err_d;

   assign rxd_s = sync_q[1];

   always_ff @(posedge clk125) begin
      if (reset) begin
         state       <= IDLE;
         sync_q      <= 2'b11;
         cnt         <= '0;
         timer       <= '0;
         word        <= '0;
         bit_cnt     <= '0;
         byte_cnt    <= '0;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_d;
         sync_q      <= {sync_q[0], rxd};
         cnt         <= cnt_d;
         timer       <= timer_d;
         word        <= word_d;
         bit_cnt     <= bit_cnt_d;
         byte_cnt    <= byte_cnt_d;
         frame_err   <= frame_err_d;
         timeout_err <= timeout_err_d;
      end
   end

   always_comb begin
      state_d       = state;
      cnt_d         = cnt;
      timer_d       = timer;
      word_d        = word;
      bit_cnt_d     = bit_cnt;
      byte_cnt_d    = byte_cnt;
      frame_err_d   = 1'b0;
      timeout_err_d = 1'b0;
      case (state)
         IDLE: begin
            if (!rxd_s) begin
               state_d = START;
               cnt_d   = HalfBit;
            end
         end
         START: begin
            if (cnt != 24'd0) begin
               cnt_d = cnt - 24'd1;
            end else if (rxd_s) begin
               // glitch: resume whatever we were doing before the false start
               state_d = (byte_cnt != 2'd0) ? GAP : IDLE;
            end else begin
               state_d   = DATA;
               cnt_d     = FullBit;
               bit_cnt_d = 3'd0;
            end
         end
         DATA: begin
            if (cnt != 24'd0) begin
               cnt_d = cnt - 24'd1;
            end else begin
               word_d    = {rxd_s, word[31:1]};
               cnt_d     = FullBit;
               bit_cnt_d = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt != 24'd0) begin
               cnt_d = cnt - 24'd1;
            end else if (!rxd_s) begin
               frame_err_d = 1'b1;
               byte_cnt_d  = 2'd0;
               state_d     = BREAK;
            end else if (byte_cnt == 2'd3) begin
               state_d = HOLD;
            end else begin
               byte_cnt_d = byte_cnt + 2'd1;
               timer_d    = ByteTimeout;
               state_d    = GAP;
            end
         end
         GAP: begin
            // a start edge wins over timer expiry in the same cycle
            if (!rxd_s) begin
               state_d = START;
               cnt_d   = HalfBit;
            end else if (timer == 24'd0) begin
               timeout_err_d = 1'b1;
               byte_cnt_d    = 2'd0;
               state_d       = IDLE;
            end else begin
               timer_d = timer - 24'd1;
            end
         end
         BREAK: begin
            if (rxd_s) state_d = IDLE;
         end
         HOLD: begin
            // rxd is ignored here; a start bit arriving now is lost
            if (cmd_ready) begin
               byte_cnt_d = 2'd0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cmd_valid    = (state == HOLD);
   assign busy         = (state != IDLE);
   assign cmd_phy_addr = word[4:0];
   assign cmd_reg_addr = word[9:5];
   assign cmd_opcode   = word[15:14];
   assign cmd_data     = word[31:16];

endmodule

// File: tb/tb_uart_mdio_cmd_rx.sv
// Testbench for uart_mdio_cmd_rx with a 16-cycle bit time and a 200-cycle
// inter-byte timeout. Expected command words are queued when a command is
// sent and compared field by field when the DUT hands a command over.

module tb_uart_mdio_cmd_rx;

   localparam int Baud = 16;

   logic        clk125 = 1'b0;
   logic        reset;
   logic        rxd;
   logic        cmd_ready;
   logic [4:0]  cmd_phy_addr;
   logic [4:0]  cmd_reg_addr;
   logic [1:0]  cmd_opcode;
   logic [15:0] cmd_data;
   logic        cmd_valid;
   logic        frame_err;
   logic        timeout_err;
   logic        busy;

   uart_mdio_cmd_rx #(
      .BaudRateDivider(16),
      .ByteTimeout    (24'd200)
   ) dut (
      .clk125      (clk125),
      .reset       (reset),
      .rxd         (rxd),
      .cmd_phy_addr(cmd_phy_addr),
      .cmd_reg_addr(cmd_reg_addr),
      .cmd_opcode  (cmd_opcode),
      .cmd_data    (cmd_data),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .frame_err   (frame_err),
      .timeout_err (timeout_err),
      .busy        (busy)
   );

   always #5 clk125 = ~clk125;

   int n_checks   = 0;
   int n_pass     = 0;
   int n_accept   = 0;
   int n_frame    = 0;
   int n_timeout  = 0;
   int n_unstable = 0;
   logic [31:0] exp_q[$];
   logic [27:0] held;
   logic        held_v = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // inputs change 2 time units after posedge; outputs sampled at negedge
   always @(negedge clk125) begin
      logic [31:0] w;
      logic [27:0] fields;
      fields = {cmd_data, cmd_opcode, cmd_reg_addr, cmd_phy_addr};
      if (frame_err)   n_frame++;
      if (timeout_err) n_timeout++;
      if (cmd_valid) begin
         if (held_v && fields != held) n_unstable++;
         held   = fields;
         held_v = 1'b1;
      end else begin
         held_v = 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
         n_accept++;
         check("cmd_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("phy",    32'(cmd_phy_addr), 32'(w[4:0]));
            check("reg",    32'(cmd_reg_addr), 32'(w[9:5]));
            check("opcode", 32'(cmd_opcode),   32'(w[15:14]));
            check("data",   32'(cmd_data),     32'(w[31:16]));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk125);
         #2;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rxd = 1'b0;
      tick(Baud);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(Baud);
      end
      rxd = stop_bit;
      tick(Baud);
   endtask

   task automatic send_cmd(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
   endtask

   task automatic wait_accepts(input int target, input int budget);
      int k = 0;
      while (n_accept < target && k < budget) begin
         tick(1);
         k++;
      end
      check("accept_count", 32'(n_accept), 32'(target));
   endtask

   initial begin
      int f0;
      int t0;
      reset     = 1'b1;
      rxd       = 1'b1;
      cmd_ready = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(1);

      check("rst_valid", 32'(cmd_valid), 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_errs",  32'({frame_err, timeout_err}), 32'd0);
      check("rst_word",  32'({cmd_data, cmd_opcode, cmd_reg_addr, cmd_phy_addr}), 32'd0);

      // command decode with consumer always ready
      cmd_ready = 1'b1;
      exp_q.push_back(32'h1234_9841);
      send_cmd(32'h1234_9841);
      wait_accepts(1, 50);

      // consumer stalls; bytes arriving during HOLD are dropped
      cmd_ready = 1'b0;
      exp_q.push_back(32'h1234_9841);
      send_cmd(32'h1234_9841);
      check("hold_valid", 32'(cmd_valid), 32'd1);
      check("hold_busy",  32'(busy), 32'd1);
      tick(50);
      send_byte(8'h55, 1'b1);
      send_byte(8'h55, 1'b1);
      tick(20);
      check("hold_valid_late", 32'(cmd_valid), 32'd1);
      check("hold_accepts",    32'(n_accept), 32'd1);
      cmd_ready = 1'b1;
      wait_accepts(2, 20);
      tick(5);
      check("hold_stable",    32'(n_unstable), 32'd0);
      check("post_hold_idle", 32'({cmd_valid, busy}), 32'd0);

      // framing error on byte 1, line held low
      f0 = n_frame;
      send_byte(8'h41, 1'b1);
      send_byte(8'h98, 1'b0);
      tick(40);
      rxd = 1'b1;
      tick(10);
      check("frame_pulses",  32'(n_frame - f0), 32'd1);
      check("frame_no_cmd",  32'(n_accept), 32'd2);
      check("frame_idle",    32'(busy), 32'd0);
      exp_q.push_back(32'hBEEF_3CA5);
      send_cmd(32'hBEEF_3CA5);
      wait_accepts(3, 50);

      // inter-byte timeout after two bytes
      t0 = n_timeout;
      send_byte(8'h41, 1'b1);
      send_byte(8'h98, 1'b1);
      tick(250);
      check("timeout_pulses", 32'(n_timeout - t0), 32'd1);
      check("timeout_idle",   32'(busy), 32'd0);
      exp_q.push_back(32'h1234_9841);
      send_cmd(32'h1234_9841);
      wait_accepts(4, 50);

      // short low glitch in IDLE
      f0 = n_frame;
      t0 = n_timeout;
      rxd = 1'b0;
      tick(4);
      rxd = 1'b1;
      tick(30);
      check("glitch_errs",   32'((n_frame - f0) + (n_timeout - t0)), 32'd0);
      check("glitch_idle",   32'(busy), 32'd0);
      check("glitch_word",   32'({cmd_data, cmd_opcode, cmd_reg_addr, cmd_phy_addr}),
            32'({16'h1234, 2'b10, 5'd2, 5'd1}));
      check("glitch_no_cmd", 32'(n_accept), 32'd4);

      // reset during byte 2
      send_byte(8'h1F, 1'b1);
      send_byte(8'hE2, 1'b1);
      rxd = 1'b0;
      tick(Baud);
      rxd = 1'b1;
      tick(Baud);
      rxd = 1'b0;
      tick(8);
      rxd   = 1'b1;
      reset = 1'b1;
      tick(1);
      check("mrst_valid", 32'(cmd_valid), 32'd0);
      check("mrst_busy",  32'(busy), 32'd0);
      check("mrst_errs",  32'({frame_err, timeout_err}), 32'd0);
      check("mrst_word",  32'({cmd_data, cmd_opcode, cmd_reg_addr, cmd_phy_addr}), 32'd0);
      reset = 1'b0;
      tick(20);
      exp_q.push_back(32'hFF00_E21F);
      send_cmd(32'hFF00_E21F);
      wait_accepts(5, 50);

      tick(20);
      check("queue_empty",   32'(exp_q.size()), 32'd0);
      check("total_frame",   32'(n_frame), 32'd1);
      check("total_timeout", 32'(n_timeout), 32'd1);
      check("total_accept",  32'(n_accept), 32'd5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
